// File: rtl/cfg_bus_arbiter.sv
// Round-robin arbiter for NUM_REQ requesters sharing one config bus.
// Writes issue back-to-back from IDLE; reads hold the bus for RD_LATENCY cycles and then return data to their owner.
module cfg_bus_arbiter #(
    parameter int NUM_REQ             = 4,
    parameter int CGRA_CFG_ADDR_WIDTH = 32,
    parameter int CGRA_CFG_DATA_WIDTH = 32,
    parameter int RD_LATENCY          = 1
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic [NUM_REQ-1:0]                                  req_vld,
    input  logic [NUM_REQ-1:0]                                  req_wr,
    input  logic [NUM_REQ-1:0][CGRA_CFG_ADDR_WIDTH-1:0]         req_addr,
    input  logic [NUM_REQ-1:0][CGRA_CFG_DATA_WIDTH-1:0]         req_data,
    output logic [NUM_REQ-1:0]                                  req_rdy,
    output logic [NUM_REQ-1:0]                                  rsp_vld,
    output logic [CGRA_CFG_DATA_WIDTH-1:0]                      rsp_data,
    output logic                                                cfg_wr_en,
    output logic [CGRA_CFG_ADDR_WIDTH-1:0]                      cfg_wr_addr,
    output logic [CGRA_CFG_DATA_WIDTH-1:0]                      cfg_wr_data,
    output logic                                                cfg_rd_en,
    output logic [CGRA_CFG_ADDR_WIDTH-1:0]                      cfg_rd_addr,
    input  logic [CGRA_CFG_DATA_WIDTH-1:0]                      cfg_rd_data,
    output logic                                                busy
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_RSP} state_t;

    state_t                         r_state, w_next;
    logic [GW-1:0]                  r_last, r_owner, w_gidx;
    logic [CW-1:0]                  r_cnt;
    logic [CGRA_CFG_ADDR_WIDTH-1:0] r_rd_addr, r_wr_addr;
    logic [CGRA_CFG_DATA_WIDTH-1:0] r_wr_data, r_rsp_data;
    logic                           r_wr_en;
    logic                           w_any, w_hs, w_hs_wr, w_hs_rd, w_rd_last;
    logic [NUM_REQ-1:0]             w_rdy;

    // Search starts one past the last winner so every requester gets a turn within NUM_REQ grants.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!w_any && req_vld[GW'((int'(r_last) + i) % NUM_REQ)]) begin
                w_any  = 1'b1;
                w_gidx = GW'((int'(r_last) + i) % NUM_REQ);
            end
        end
    end

    assign w_hs      = w_any && (r_state == S_IDLE) && !reset;
    assign w_hs_wr   = w_hs && req_wr[w_gidx];
    assign w_hs_rd   = w_hs && !req_wr[w_gidx];
    assign w_rd_last = (r_state == S_RD) && (r_cnt == CW'(RD_LATENCY - 1));

    always_comb begin
        w_rdy = '0;
        if (w_hs) w_rdy[w_gidx] = 1'b1;
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_hs_rd)   w_next = S_RD;
            S_RD:    if (w_rd_last) w_next = S_RSP;
            S_RSP:                  w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_rdy     = w_rdy;
        busy        = (r_state != S_IDLE);
        cfg_rd_en   = (r_state == S_RD);
        cfg_rd_addr = (r_state == S_RD) ? r_rd_addr : '0;
        rsp_vld     = '0;
        if (r_state == S_RSP) rsp_vld[r_owner] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last     <= GW'(NUM_REQ - 1);
            r_owner    <= '0;
            r_cnt      <= '0;
            r_rd_addr  <= '0;
            r_rsp_data <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en   <= w_hs_wr;
            r_wr_addr <= w_hs_wr ? req_addr[w_gidx] : '0;
            r_wr_data <= w_hs_wr ? req_data[w_gidx] : '0;
            if (w_hs) r_last <= w_gidx;
            if (w_hs_rd) begin
                r_owner   <= w_gidx;
                r_rd_addr <= req_addr[w_gidx];
                r_cnt     <= '0;
            end else if (r_state == S_RD) begin
                r_cnt <= r_cnt + CW'(1);
                if (w_rd_last) r_rsp_data <= cfg_rd_data;
            end
        end
    end

    assign cfg_wr_en   = r_wr_en;
    assign cfg_wr_addr = r_wr_en ? r_wr_addr : '0;
    assign cfg_wr_data = r_wr_en ? r_wr_data : '0;
    assign rsp_data    = r_rsp_data;

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// Directed and randomized checks of cfg_bus_arbiter; instance 0 uses RD_LATENCY=1, instance 1 uses RD_LATENCY=3.
module tb_cfg_bus_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NR-1:0]         vld [2];
    logic [NR-1:0]         wr  [2];
    logic [NR-1:0][AW-1:0] addr[2];
    logic [NR-1:0][DW-1:0] wdat[2];
    logic [DW-1:0]         rdd [2];
    logic [NR-1:0]         rdy [2];
    logic [NR-1:0]         rspv[2];
    logic [DW-1:0]         rspd[2];
    logic                  wen [2];
    logic [AW-1:0]         wadr[2];
    logic [DW-1:0]         wdt [2];
    logic                  ren [2];
    logic [AW-1:0]         radr[2];
    logic                  bsy [2];

    int checks   = 0;
    int failures = 0;

    cfg_bus_arbiter #(.NUM_REQ(NR), .CGRA_CFG_ADDR_WIDTH(AW), .CGRA_CFG_DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset), .req_vld(vld[0]), .req_wr(wr[0]), .req_addr(addr[0]), .req_data(wdat[0]),
        .req_rdy(rdy[0]), .rsp_vld(rspv[0]), .rsp_data(rspd[0]), .cfg_wr_en(wen[0]), .cfg_wr_addr(wadr[0]),
        .cfg_wr_data(wdt[0]), .cfg_rd_en(ren[0]), .cfg_rd_addr(radr[0]), .cfg_rd_data(rdd[0]), .busy(bsy[0]));

    cfg_bus_arbiter #(.NUM_REQ(NR), .CGRA_CFG_ADDR_WIDTH(AW), .CGRA_CFG_DATA_WIDTH(DW), .RD_LATENCY(3)) u_dut_l3 (
        .clk(clk), .reset(reset), .req_vld(vld[1]), .req_wr(wr[1]), .req_addr(addr[1]), .req_data(wdat[1]),
        .req_rdy(rdy[1]), .rsp_vld(rspv[1]), .rsp_data(rspd[1]), .cfg_wr_en(wen[1]), .cfg_wr_addr(wadr[1]),
        .cfg_wr_data(wdt[1]), .cfg_rd_en(ren[1]), .cfg_rd_addr(radr[1]), .cfg_rd_data(rdd[1]), .busy(bsy[1]));

    // Each cycle: inputs change 1 ns after the rising edge, outputs are checked 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            vld[d]  = '0;
            wr[d]   = '0;
            addr[d] = '0;
            wdat[d] = '0;
            rdd[d]  = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        #2;
        reset  = 1'b1;
        vld[0] = 4'b1111;
        wr[0]  = 4'b1111;
        #1;
        checks++; if (rdy[0] !== 4'b0000) begin failures++; $display("FAIL reset_rdy got=%b exp=0000", rdy[0]); end
        checks++; if (wen[0] !== 1'b0 || ren[0] !== 1'b0 || bsy[0] !== 1'b0) begin failures++; $display("FAIL reset_ctrl wen=%b ren=%b busy=%b exp=000", wen[0], ren[0], bsy[0]); end
        checks++; if (rspd[0] !== 32'h0 || rspv[0] !== 4'b0) begin failures++; $display("FAIL reset_rsp data=%h vld=%b exp=0", rspd[0], rspv[0]); end
        step();
        step();
        checks++; if (wen[0] !== 1'b0 || wadr[0] !== 32'h0) begin failures++; $display("FAIL reset_no_write wen=%b addr=%h exp=0", wen[0], wadr[0]); end
        clear_inputs();
        reset = 1'b0;
    endtask

    task automatic test_rr_writes();
        logic [NR-1:0] e;
        for (int i = 0; i < NR; i++) begin
            addr[0][i] = 32'h100 + i;
            wdat[0][i] = 32'hA0 + i;
        end
        for (int k = 0; k < 5; k++) begin
            vld[0] = 4'b1111;
            wr[0]  = 4'b1111;
            #1;
            e = '0;
            e[k % NR] = 1'b1;
            checks++; if (rdy[0] !== e) begin failures++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, rdy[0], e); end
            if (k > 0) begin
                checks++;
                if (wen[0] !== 1'b1 || wadr[0] !== 32'h100 + (k - 1) % NR || wdt[0] !== 32'hA0 + (k - 1) % NR) begin
                    failures++; $display("FAIL rr_write k=%0d wen=%b addr=%h data=%h exp_addr=%h", k, wen[0], wadr[0], wdt[0], 32'h100 + (k - 1) % NR);
                end
            end else begin
                checks++; if (wen[0] !== 1'b0) begin failures++; $display("FAIL rr_first_wen got=%b exp=0", wen[0]); end
            end
            step();
        end
        vld[0] = '0;
        #1;
        checks++; if (rdy[0] !== 4'b0 || wen[0] !== 1'b1 || wadr[0] !== 32'h100 || wdt[0] !== 32'hA0) begin
            failures++; $display("FAIL rr_last_write rdy=%b wen=%b addr=%h data=%h exp addr=100 data=a0", rdy[0], wen[0], wadr[0], wdt[0]);
        end
        step();
        #1;
        checks++; if (wen[0] !== 1'b0 || wadr[0] !== 32'h0 || wdt[0] !== 32'h0) begin
            failures++; $display("FAIL rr_idle_write wen=%b addr=%h data=%h exp=0", wen[0], wadr[0], wdt[0]);
        end
        step();
    endtask

    task automatic test_single();
        for (int k = 0; k < 3; k++) begin
            vld[0] = 4'b0100;
            wr[0]  = 4'b0100;
            #1;
            checks++; if (rdy[0] !== 4'b0100) begin failures++; $display("FAIL single_grant k=%0d got=%b exp=0100", k, rdy[0]); end
            step();
        end
        clear_inputs();
        step();
    endtask

    task automatic test_read_lat1();
        vld[0]     = 4'b0100;
        wr[0]      = 4'b0000;
        addr[0][2] = 32'h10000005;
        rdd[0]     = 32'hCAFE;
        #1;
        checks++; if (rdy[0] !== 4'b0100) begin failures++; $display("FAIL rd1_grant got=%b exp=0100", rdy[0]); end
        step();
        vld[0] = '0;
        #1;
        checks++; if (ren[0] !== 1'b1 || radr[0] !== 32'h10000005 || bsy[0] !== 1'b1) begin
            failures++; $display("FAIL rd1_bus ren=%b addr=%h busy=%b exp 1/10000005/1", ren[0], radr[0], bsy[0]);
        end
        checks++; if (rspv[0] !== 4'b0 || wen[0] !== 1'b0) begin failures++; $display("FAIL rd1_early rsp=%b wen=%b exp=0", rspv[0], wen[0]); end
        step();
        #1;
        checks++; if (rspv[0] !== 4'b0100 || rspd[0] !== 32'hCAFE || bsy[0] !== 1'b1 || ren[0] !== 1'b0 || radr[0] !== 32'h0) begin
            failures++; $display("FAIL rd1_rsp rsp=%b data=%h busy=%b ren=%b addr=%h exp 0100/cafe/1/0/0", rspv[0], rspd[0], bsy[0], ren[0], radr[0]);
        end
        rdd[0] = 32'h5555;
        step();
        #1;
        checks++; if (rspv[0] !== 4'b0 || bsy[0] !== 1'b0 || rspd[0] !== 32'hCAFE) begin
            failures++; $display("FAIL rd1_after rsp=%b busy=%b data=%h exp 0/0/cafe", rspv[0], bsy[0], rspd[0]);
        end
        step();
    endtask

    task automatic test_wr_then_rd();
        vld[0]     = 4'b0001;
        wr[0]      = 4'b0001;
        addr[0][0] = 32'h200;
        wdat[0][0] = 32'h11;
        #1;
        checks++; if (rdy[0] !== 4'b0001) begin failures++; $display("FAIL wr_rd_grant0 got=%b exp=0001", rdy[0]); end
        step();
        vld[0]     = 4'b0010;
        wr[0]      = 4'b0000;
        addr[0][1] = 32'h300;
        rdd[0]     = 32'h1234;
        #1;
        checks++; if (rdy[0] !== 4'b0010 || wen[0] !== 1'b1 || wadr[0] !== 32'h200 || ren[0] !== 1'b0) begin
            failures++; $display("FAIL wr_rd_t1 rdy=%b wen=%b addr=%h ren=%b exp 0010/1/200/0", rdy[0], wen[0], wadr[0], ren[0]);
        end
        step();
        vld[0] = '0;
        #1;
        checks++; if (wen[0] !== 1'b0 || ren[0] !== 1'b1 || radr[0] !== 32'h300) begin
            failures++; $display("FAIL wr_rd_t2 wen=%b ren=%b addr=%h exp 0/1/300", wen[0], ren[0], radr[0]);
        end
        step();
        #1;
        checks++; if (rspv[0] !== 4'b0010 || rspd[0] !== 32'h1234 || ren[0] !== 1'b0 || wen[0] !== 1'b0) begin
            failures++; $display("FAIL wr_rd_t3 rsp=%b data=%h ren=%b wen=%b exp 0010/1234/0/0", rspv[0], rspd[0], ren[0], wen[0]);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_hold_lat3();
        vld[1]     = 4'b1010;
        wr[1]      = 4'b1000;
        addr[1][1] = 32'h400;
        addr[1][3] = 32'h500;
        wdat[1][3] = 32'h55;
        rdd[1]     = 32'hBEEF;
        #1;
        checks++; if (rdy[1] !== 4'b0010) begin failures++; $display("FAIL hold_grant1 got=%b exp=0010", rdy[1]); end
        step();
        vld[1] = 4'b1000;
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++; if (ren[1] !== 1'b1 || radr[1] !== 32'h400 || rdy[1] !== 4'b0 || rspv[1] !== 4'b0) begin
                failures++; $display("FAIL hold_rd c=%0d ren=%b addr=%h rdy=%b rsp=%b exp 1/400/0/0", c, ren[1], radr[1], rdy[1], rspv[1]);
            end
            step();
        end
        #1;
        checks++; if (rspv[1] !== 4'b0010 || rspd[1] !== 32'hBEEF || rdy[1] !== 4'b0 || ren[1] !== 1'b0) begin
            failures++; $display("FAIL hold_rsp rsp=%b data=%h rdy=%b ren=%b exp 0010/beef/0/0", rspv[1], rspd[1], rdy[1], ren[1]);
        end
        step();
        #1;
        checks++; if (rdy[1] !== 4'b1000 || bsy[1] !== 1'b0) begin failures++; $display("FAIL hold_grant3 rdy=%b busy=%b exp 1000/0", rdy[1], bsy[1]); end
        step();
        vld[1] = '0;
        #1;
        checks++; if (wen[1] !== 1'b1 || wadr[1] !== 32'h500 || wdt[1] !== 32'h55) begin
            failures++; $display("FAIL hold_write wen=%b addr=%h data=%h exp 1/500/55", wen[1], wadr[1], wdt[1]);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_reset_mid_rd();
        vld[1]     = 4'b0100;
        wr[1]      = 4'b0000;
        addr[1][2] = 32'h600;
        #1;
        checks++; if (rdy[1] !== 4'b0100) begin failures++; $display("FAIL midrst_grant got=%b exp=0100", rdy[1]); end
        step();
        #1;
        step();
        #1;
        checks++; if (ren[1] !== 1'b1 || bsy[1] !== 1'b1) begin failures++; $display("FAIL midrst_in_rd ren=%b busy=%b exp 1/1", ren[1], bsy[1]); end
        reset = 1'b1;
        #1;
        checks++; if (ren[1] !== 1'b0 || radr[1] !== 32'h0 || bsy[1] !== 1'b0 || rdy[1] !== 4'b0 || rspv[1] !== 4'b0 || rspd[1] !== 32'h0 || wen[1] !== 1'b0) begin
            failures++; $display("FAIL midrst_zero ren=%b addr=%h busy=%b rdy=%b rsp=%b data=%h wen=%b exp all 0", ren[1], radr[1], bsy[1], rdy[1], rspv[1], rspd[1], wen[1]);
        end
        step();
        step();
        vld[1] = '0;
        reset  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (rspv[1] !== 4'b0 || bsy[1] !== 1'b0) begin failures++; $display("FAIL midrst_no_rsp c=%0d rsp=%b busy=%b exp 0/0", c, rspv[1], bsy[1]); end
            step();
        end
        vld[1] = 4'b1111;
        wr[1]  = 4'b1111;
        #1;
        checks++; if (rdy[1] !== 4'b0001) begin failures++; $display("FAIL midrst_next_grant got=%b exp=0001", rdy[1]); end
        step();
        clear_inputs();
    endtask

    task automatic test_random();
        logic [NR-1:0] pend, erdy, ersp;
        logic [DW-1:0] cap, mwd;
        logic [AW-1:0] mwa;
        logic          mwr;
        int            mlast, mbusy, mown, g, reads, rsps, nfail;
        int            waitc[NR];
        do_reset();
        pend  = '0;
        mlast = NR - 1;
        mbusy = 0;
        mown  = 0;
        mwr   = 1'b0;
        mwa   = '0;
        mwd   = '0;
        cap   = '0;
        reads = 0;
        rsps  = 0;
        nfail = failures;
        for (int i = 0; i < NR; i++) waitc[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && cyc < 9990 && $urandom_range(0, 3) == 0) begin
                    pend[i]    = 1'b1;
                    wr[0][i]   = 1'($urandom_range(0, 1));
                    addr[0][i] = $urandom;
                    wdat[0][i] = $urandom;
                end
            end
            vld[0] = pend;
            rdd[0] = $urandom;
            #1;
            g = -1;
            if (mbusy == 0) begin
                for (int j = 1; j <= NR; j++) begin
                    if (g < 0 && pend[(mlast + j) % NR]) g = (mlast + j) % NR;
                end
            end
            erdy = '0;
            if (g >= 0) erdy[g] = 1'b1;
            ersp = '0;
            if (mbusy == 1) ersp[mown] = 1'b1;
            checks++; if (rdy[0] !== erdy || !$onehot0(rdy[0])) begin failures++; if (failures - nfail < 10) $display("FAIL rand_rdy cyc=%0d got=%b exp=%b", cyc, rdy[0], erdy); end
            checks++; if (rspv[0] !== ersp) begin failures++; if (failures - nfail < 10) $display("FAIL rand_rsp cyc=%0d got=%b exp=%b", cyc, rspv[0], ersp); end
            if (rspv[0] !== 4'b0 && rspv[0] === ersp) rsps++;
            if (mbusy == 1) begin
                checks++; if (rspd[0] !== cap) begin failures++; if (failures - nfail < 10) $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", cyc, rspd[0], cap); end
            end
            checks++; if (ren[0] !== (mbusy > 1) || (ren[0] === 1'b1 && wen[0] === 1'b1)) begin
                failures++; if (failures - nfail < 10) $display("FAIL rand_ren cyc=%0d got=%b exp=%b wen=%b", cyc, ren[0], (mbusy > 1), wen[0]);
            end
            checks++; if (wen[0] !== mwr || (mwr && (wadr[0] !== mwa || wdt[0] !== mwd))) begin
                failures++; if (failures - nfail < 10) $display("FAIL rand_wr cyc=%0d wen=%b addr=%h data=%h exp %b/%h/%h", cyc, wen[0], wadr[0], wdt[0], mwr, mwa, mwd);
            end
            if (mbusy == 2) cap = rdd[0];
            if (mbusy > 0) mbusy--;
            mwr = 1'b0;
            if (g >= 0) begin
                for (int i = 0; i < NR; i++) if (i != g && pend[i]) waitc[i]++;
                checks++; if (waitc[g] > NR - 1) begin failures++; $display("FAIL rand_starve cyc=%0d req=%0d waited=%0d max=%0d", cyc, g, waitc[g], NR - 1); end
                waitc[g] = 0;
                mlast    = g;
                if (wr[0][g]) begin
                    mwr = 1'b1;
                    mwa = addr[0][g];
                    mwd = wdat[0][g];
                end else begin
                    mbusy = 2;
                    mown  = g;
                    reads++;
                end
                pend[g] = 1'b0;
            end
            step();
        end
        checks++; if (rsps !== reads) begin failures++; $display("FAIL rand_rsp_count got=%0d exp=%0d", rsps, reads); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_rr_writes();
        test_single();
        test_read_lat1();
        test_wr_then_rd();
        test_hold_lat3();
        test_reset_mid_rd();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
